// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and response FSM encoding
// Used by alu, alu_arbiter and instruction_decoder.
package alu_pkg;

    localparam logic [2:0] OP_NOOP = 3'b000;
    localparam logic [2:0] OP_ILL  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_SUBI = 3'b111;

    // EMPTY: no response held; FULL: response register valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return op == OP_ILL;
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU (add, sub, logical shifts)
// Ports:
//   op_i     - ALU control code
//   src_a_i  - first operand
//   src_b_i  - second operand; bits [4:0] are the shift amount
//   result_o - result, 0 for NOOP and for the illegal code
//   err_o    - op_i is the illegal code
module alu
    import alu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    output logic [31:0] result_o,
    output logic        err_o
);

    always_comb begin
        result_o = 32'd0;
        err_o    = op_is_illegal(op_i);
        case (op_i)
            OP_ADD, OP_ADDI: result_o = src_a_i + src_b_i;
            OP_SUB, OP_SUBI: result_o = src_a_i - src_b_i;
            OP_SHL:          result_o = src_a_i << src_b_i[4:0];
            OP_SHR:          result_o = src_a_i >> src_b_i[4:0];
            default:         result_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared ALU with a registered response
// Ports:
//   clk, rst_n               - clock, synchronous active-low reset
//   reqN_valid / reqN_ready  - requester N handshake (ready is combinational from the grant)
//   reqN_src_a/_b, reqN_op   - requester N operands and ALU code
//   rsp_valid / rsp_ready    - response handshake
//   rsp_result, rsp_id       - registered result and owning requester
//   rsp_err                  - response came from the illegal code
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_src_a,
    input  logic [31:0] req0_src_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_src_a,
    input  logic [31:0] req1_src_b,
    input  logic [2:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_id,
    output logic        rsp_err
);

    rsp_state_e  state_q, state_d;
    logic        last_grant_q;
    logic [31:0] rsp_result_q;
    logic        rsp_id_q;
    logic        rsp_err_q;

    logic        can_acc;
    logic        gnt_any;
    logic        gnt_id;
    logic        accept;
    logic [31:0] mux_a;
    logic [31:0] mux_b;
    logic [2:0]  mux_op;
    logic [31:0] alu_result;
    logic        alu_err;

    // On a tie, round-robin picks the requester not granted last;
    // fixed priority always picks requester 0. With one requester
    // valid, gnt_id simply points at it.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = (RR_EN != 0) ? ~last_grant_q : 1'b0;
        end else begin
            gnt_id = ~req0_valid;
        end
    end

    // rst_n gates accept so no ready is raised while in reset.
    assign can_acc    = !rsp_valid || rsp_ready;
    assign accept     = rst_n && can_acc && gnt_any;
    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept && gnt_id;

    assign mux_a  = gnt_id ? req1_src_a : req0_src_a;
    assign mux_b  = gnt_id ? req1_src_b : req0_src_b;
    assign mux_op = gnt_id ? req1_op    : req0_op;

    alu u_alu (
        .op_i     (mux_op),
        .src_a_i  (mux_a),
        .src_b_i  (mux_b),
        .result_o (alu_result),
        .err_o    (alu_err)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (!accept && rsp_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // FSM outputs
    always_comb begin
        rsp_valid = (state_q == ST_FULL);
    end

    // Response payload and grant history only move on an accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_result_q <= 32'd0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            rsp_result_q <= alu_result;
            rsp_id_q     <= gnt_id;
            rsp_err_q    <= alu_err;
            last_grant_q <= gnt_id;
        end
    end

    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter (round-robin and fixed-priority instances)
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  op0, op1;
    logic        rsp_ready;

    logic        rdy0_w [2];
    logic        rdy1_w [2];
    logic        rv_w   [2];
    logic [31:0] rres_w [2];
    logic        rid_w  [2];
    logic        rerr_w [2];

    int checks = 0;
    int passes = 0;

    // Reference state per instance: 0 = round-robin, 1 = fixed priority.
    bit          m_valid [2];
    logic [31:0] m_res   [2];
    bit          m_id    [2];
    bit          m_err   [2];
    bit          m_last  [2];
    int          g_exp   [2];

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(rdy0_w[0]), .req0_src_a(a0), .req0_src_b(b0), .req0_op(op0),
        .req1_valid(v1), .req1_ready(rdy1_w[0]), .req1_src_a(a1), .req1_src_b(b1), .req1_op(op1),
        .rsp_valid(rv_w[0]), .rsp_ready(rsp_ready), .rsp_result(rres_w[0]),
        .rsp_id(rid_w[0]), .rsp_err(rerr_w[0])
    );

    alu_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(rdy0_w[1]), .req0_src_a(a0), .req0_src_b(b0), .req0_op(op0),
        .req1_valid(v1), .req1_ready(rdy1_w[1]), .req1_src_a(a1), .req1_src_b(b1), .req1_op(op1),
        .rsp_valid(rv_w[1]), .rsp_ready(rsp_ready), .rsp_result(rres_w[1]),
        .rsp_id(rid_w[1]), .rsp_err(rerr_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // {err, result} from the opcode table with plain arithmetic.
    function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        int          sh;
        sh = int'(b % 32);
        case (op)
            3'd0:       return {1'b0, 32'd0};
            3'd1:       return {1'b1, 32'd0};
            3'd2, 3'd6: return {1'b0, a + b};
            3'd3, 3'd7: return {1'b0, a - b};
            3'd4: begin
                prod = 64'(a) * (64'd1 << sh);
                return {1'b0, prod[31:0]};
            end
            default:    return {1'b0, a / (32'd1 << sh)};
        endcase
    endfunction

    // Which requester should be granted this cycle (-1: none).
    function automatic int exp_grant(input int k);
        if (!rst_n) return -1;
        if (m_valid[k] && !rsp_ready) return -1;
        if (v0 && v1) begin
            if (k == 1) return 0;
            return m_last[k] ? 0 : 1;
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Called just after a falling edge with inputs already applied.
    task automatic cycle();
        logic [32:0] r;
        #1;
        for (int k = 0; k < 2; k++) begin
            g_exp[k] = exp_grant(k);
            chk($sformatf("i%0d_req0_ready", k), 32'(rdy0_w[k]), 32'(g_exp[k] == 0));
            chk($sformatf("i%0d_req1_ready", k), 32'(rdy1_w[k]), 32'(g_exp[k] == 1));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_valid[k] = 0; m_res[k] = 32'd0; m_id[k] = 0; m_err[k] = 0; m_last[k] = 1;
            end else if (g_exp[k] >= 0) begin
                r = (g_exp[k] == 0) ? ref_alu(op0, a0, b0) : ref_alu(op1, a1, b1);
                m_valid[k] = 1;
                m_res[k]   = r[31:0];
                m_err[k]   = r[32];
                m_id[k]    = (g_exp[k] == 1);
                m_last[k]  = (g_exp[k] == 1);
            end else if (m_valid[k] && rsp_ready) begin
                m_valid[k] = 0;
            end
            chk($sformatf("i%0d_rsp_valid", k),  32'(rv_w[k]),   32'(m_valid[k]));
            chk($sformatf("i%0d_rsp_result", k), rres_w[k],      m_res[k]);
            chk($sformatf("i%0d_rsp_id", k),     32'(rid_w[k]),  32'(m_id[k]));
            chk($sformatf("i%0d_rsp_err", k),    32'(rerr_w[k]), 32'(m_err[k]));
        end
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0; m_res[k] = 32'd0; m_id[k] = 0; m_err[k] = 0; m_last[k] = 1; g_exp[k] = -1;
        end
        rst_n = 1'b0; rsp_ready = 1'b0;
        v0 = 0; a0 = 32'd0; b0 = 32'd0; op0 = 3'd0;
        v1 = 0; a1 = 32'd0; b1 = 32'd0; op1 = 3'd0;
        @(negedge clk);
        v0 = 1; v1 = 1;
        cycle();
        cycle();
        chk("reset_rsp_valid", 32'(rv_w[0]), 32'd0);
        chk("reset_rsp_result", rres_w[0], 32'd0);

        // Single ADD from requester 0.
        rst_n = 1'b1; rsp_ready = 1'b1;
        v0 = 1; op0 = 3'b010; a0 = 32'd5; b0 = 32'd7; v1 = 0;
        cycle();
        chk("add_valid", 32'(rv_w[0]), 32'd1);
        chk("add_result", rres_w[0], 32'd12);
        chk("add_id", 32'(rid_w[0]), 32'd0);
        chk("add_err", 32'(rerr_w[0]), 32'd0);
        v0 = 0;
        cycle();

        // Fresh tie history, then alternating round-robin grants.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        v0 = 1; op0 = 3'b010; a0 = 32'd1;  b0 = 32'd1;
        v1 = 1; op1 = 3'b011; a1 = 32'd10; b1 = 32'd3;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("rr_id_%0d", i), 32'(rid_w[0]), 32'(i % 2));
            chk($sformatf("rr_valid_%0d", i), 32'(rv_w[0]), 32'd1);
            chk($sformatf("fp_id_%0d", i), 32'(rid_w[1]), 32'd0);
        end

        // Stall: response frozen at SUB 10,3 from requester 1.
        rsp_ready = 1'b0;
        a0 = 32'd100; b0 = 32'd1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("stall_result_%0d", i), rres_w[0], 32'd7);
            chk($sformatf("stall_id_%0d", i), 32'(rid_w[0]), 32'd1);
        end
        rsp_ready = 1'b1;
        cycle();
        chk("unstall_result", rres_w[0], 32'd101);
        chk("unstall_id", 32'(rid_w[0]), 32'd0);

        // Requester 1 arithmetic and shift corners.
        v0 = 0; v1 = 1;
        op1 = 3'b011; a1 = 32'd3; b1 = 32'd5;
        cycle();
        chk("sub_wrap", rres_w[0], 32'hFFFF_FFFE);
        op1 = 3'b100; a1 = 32'd1; b1 = 32'd33;
        cycle();
        chk("shl_mod32", rres_w[0], 32'd2);
        op1 = 3'b101; a1 = 32'h8000_0000; b1 = 32'd31;
        cycle();
        chk("shr_31", rres_w[0], 32'd1);
        chk("shr_id", 32'(rid_w[0]), 32'd1);

        // Illegal opcode, then fixed priority under constant ties.
        v1 = 0; v0 = 1; op0 = 3'b001; a0 = 32'd9; b0 = 32'd9;
        cycle();
        chk("ill_result", rres_w[0], 32'd0);
        chk("ill_err", 32'(rerr_w[0]), 32'd1);
        v1 = 1; op0 = 3'b010; op1 = 3'b110;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("fp_tie_id_%0d", i), 32'(rid_w[1]), 32'd0);
        end

        // Reset while FULL drops the response; next tie goes to requester 0.
        rsp_ready = 1'b0;
        cycle();
        rst_n = 1'b0; rsp_ready = 1'b1;
        cycle();
        chk("rst_full_valid", 32'(rv_w[0]), 32'd0);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_tie_id", 32'(rid_w[0]), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 39) != 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            v0  = $urandom_range(0, 1);
            v1  = $urandom_range(0, 1);
            op0 = 3'($urandom_range(0, 7));
            op1 = 3'($urandom_range(0, 7));
            a0  = $urandom; b0 = $urandom;
            a1  = $urandom; b1 = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
